// File: rtl/load_store_unit_pkg.sv
// Shared memory-operation definitions for the load/store path: operation
// encoding, access-size encoding and small decode helpers.
package definitions;

    typedef logic [31:0] t_address;
    typedef logic [31:0] t_data;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } t_mem_op;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } t_size;

    function automatic t_size op_size(input t_mem_op op);
        case (op)
            LB, LBU, SB: op_size = SIZE_B;
            LH, LHU, SH: op_size = SIZE_H;
            default:     op_size = SIZE_W;
        endcase
    endfunction

    function automatic logic op_is_store(input t_mem_op op);
        op_is_store = (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic op_is_signed(input t_mem_op op);
        op_is_signed = (op == LB) || (op == LH);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane alignment for the load/store unit: store mask and lane-shifted
// data across a two-word window, and load extraction with sign/zero extension.
module lsu_align
    import definitions::*;
(
    input  t_mem_op     op,
    input  logic [1:0]  offset,
    input  t_data       store_data,
    input  t_data       low_word,
    input  t_data       high_word,
    output logic [7:0]  mask,
    output logic [63:0] shifted_data,
    output t_data       load_data
);

    logic [3:0]  size_mask;
    logic [5:0]  shift;
    logic [63:0] load_window;

    // Lane mask and shifted store data over the {high, low} word pair; load extraction.
    always_comb begin
        shift = {1'b0, offset, 3'b000};
        case (op_size(op))
            SIZE_B:  size_mask = 4'b0001;
            SIZE_H:  size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        mask         = {4'b0000, size_mask} << offset;
        shifted_data = {32'h0000_0000, store_data} << shift;
        load_window  = {high_word, low_word} >> shift;
        case (op_size(op))
            SIZE_B: begin
                if (op_is_signed(op)) begin
                    load_data = {{24{load_window[7]}}, load_window[7:0]};
                end else begin
                    load_data = {24'h00_0000, load_window[7:0]};
                end
            end
            SIZE_H: begin
                if (op_is_signed(op)) begin
                    load_data = {{16{load_window[15]}}, load_window[15:0]};
                end else begin
                    load_data = {16'h0000, load_window[15:0]};
                end
            end
            default: load_data = load_window[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-port initiator: one load/store at a time, split into two word accesses
// when it crosses a word boundary. Macro LSU_MISALIGNED_EN enables split accesses.
module load_store_unit
    import definitions::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  t_mem_op    i_op,
    input  t_address   i_address,
    input  t_data      i_store_data,
    output logic       o_done,
    output t_data      o_load_data,
    output logic       o_misaligned,
    output t_address   o_mem_address,
    output t_data      o_mem_data,
    output logic [3:0] o_mem_write_mask,
    output logic       o_mem_write_enable,
    input  t_data      i_mem_data
);

`ifdef LSU_MISALIGNED_EN
    localparam logic MISALIGNED_EN = 1'b1;
`else
    localparam logic MISALIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS1 = 2'd1,
        ACCESS2 = 2'd2,
        RESPOND = 2'd3
    } t_lsu_state;

    t_lsu_state  state_r;
    t_lsu_state  state_next;
    t_mem_op     op_r;
    t_address    address_r;
    t_data       store_data_r;
    t_data       low_r;
    t_data       high_r;
    logic [7:0]  mask_s;
    logic [63:0] shifted_s;
    t_data       extended_s;
    logic        split_s;
    logic        blocked_s;
    logic        is_store_s;
    t_address    word_address_s;

    lsu_align u_align (
        .op           (op_r),
        .offset       (address_r[1:0]),
        .store_data   (store_data_r),
        .low_word     (low_r),
        .high_word    (high_r),
        .mask         (mask_s),
        .shifted_data (shifted_s),
        .load_data    (extended_s)
    );

    assign split_s        = (mask_s[7:4] != 4'b0000);
    assign blocked_s      = split_s & ~MISALIGNED_EN;
    assign is_store_s     = op_is_store(op_r);
    assign word_address_s = {address_r[31:2], 2'b00};

    // State register and request/read-buffer capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= IDLE;
            op_r         <= LB;
            address_r    <= 32'h0000_0000;
            store_data_r <= 32'h0000_0000;
            low_r        <= 32'h0000_0000;
            high_r       <= 32'h0000_0000;
        end else begin
            state_r <= state_next;
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        op_r         <= i_op;
                        address_r    <= i_address;
                        store_data_r <= i_store_data;
                        high_r       <= 32'h0000_0000;
                    end
                end
                ACCESS1: low_r  <= i_mem_data;
                ACCESS2: high_r <= i_mem_data;
                default: ;
            endcase
        end
    end

    // Next-state decode and memory/response outputs for the current state.
    always_comb begin
        state_next         = state_r;
        o_ready            = 1'b0;
        o_done             = 1'b0;
        o_load_data        = 32'h0000_0000;
        o_misaligned       = 1'b0;
        o_mem_address      = 32'h0000_0000;
        o_mem_data         = 32'h0000_0000;
        o_mem_write_mask   = 4'b0000;
        o_mem_write_enable = 1'b0;
        case (state_r)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_next = ACCESS1;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS1: begin
                o_mem_address = word_address_s;
                // A blocked misaligned store still walks ACCESS1 but never writes.
                if (is_store_s && !blocked_s) begin
                    o_mem_write_enable = 1'b1;
                    o_mem_write_mask   = mask_s[3:0];
                    o_mem_data         = shifted_s[31:0];
                end else begin
                    o_mem_write_enable = 1'b0;
                end
                if (split_s && MISALIGNED_EN) begin
                    state_next = ACCESS2;
                end else begin
                    state_next = RESPOND;
                end
            end
            ACCESS2: begin
                o_mem_address = word_address_s + 32'd4;
                if (is_store_s) begin
                    o_mem_write_enable = 1'b1;
                    o_mem_write_mask   = mask_s[7:4];
                    o_mem_data         = shifted_s[63:32];
                end else begin
                    o_mem_write_enable = 1'b0;
                end
                state_next = RESPOND;
            end
            RESPOND: begin
                o_done       = 1'b1;
                o_misaligned = blocked_s;
                if (!is_store_s && !blocked_s) begin
                    o_load_data = extended_s;
                end else begin
                    o_load_data = 32'h0000_0000;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: fixed vectors from the memory-map scenarios, reset
// corner cases, and random operations against a byte-array reference model.
module tb_load_store_unit;
    import definitions::*;

`ifdef LSU_MISALIGNED_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    t_mem_op     i_op;
    logic [31:0] i_address;
    logic [31:0] i_store_data;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_write_mask;
    logic        o_mem_write_enable;
    logic [31:0] i_mem_data;

    load_store_unit dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_op               (i_op),
        .i_address          (i_address),
        .i_store_data       (i_store_data),
        .o_done             (o_done),
        .o_load_data        (o_load_data),
        .o_misaligned       (o_misaligned),
        .o_mem_address      (o_mem_address),
        .o_mem_data         (o_mem_data),
        .o_mem_write_mask   (o_mem_write_mask),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_data         (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    // Eight-word memory, aliased over the whole address space.
    logic [31:0] mem [0:7];
    logic [31:0] preload_val [0:7];
    logic        preload_en = 1'b0;

    assign i_mem_data = mem[o_mem_address[4:2]];

    always @(posedge i_clk) begin
        if (preload_en) begin
            for (int w = 0; w < 8; w++) mem[w] <= preload_val[w];
        end else if (o_mem_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_write_mask[b]) mem[o_mem_address[4:2]][8*b +: 8] <= o_mem_data[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] w0, input logic [31:0] w1, input bit rnd);
        for (int w = 0; w < 8; w++) preload_val[w] = rnd ? $urandom : 32'h0;
        preload_val[0] = w0;
        preload_val[1] = w1;
        @(negedge i_clk);
        preload_en = 1'b1;
        @(posedge i_clk);
        #1 preload_en = 1'b0;
    endtask

    // Results of the last operation, filled by do_op.
    logic [31:0] got_data;
    logic        got_mis;
    int          got_n;
    int          nwr;
    logic [31:0] w_addr [0:3];
    logic [3:0]  w_mask [0:3];
    logic [31:0] w_data [0:3];

    task automatic do_op(input t_mem_op op, input logic [31:0] addr, input logic [31:0] sd);
        bit seen_done = 1'b0;
        bit addr_bad  = 1'b0;
        nwr = 0;
        got_n = -1;
        got_data = 32'hx;
        got_mis = 1'bx;
        @(negedge i_clk);
        chk("ready_before", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_op = op; i_address = addr; i_store_data = sd;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        i_address = $urandom; i_store_data = $urandom;
        for (int c = 0; c < 8 && !seen_done; c++) begin
            @(negedge i_clk);
            if (o_mem_address[1:0] != 2'b00) addr_bad = 1'b1;
            if (o_mem_write_enable) begin
                if (nwr < 4) begin
                    w_addr[nwr] = o_mem_address;
                    w_mask[nwr] = o_mem_write_mask;
                    w_data[nwr] = o_mem_data;
                end
                nwr++;
            end
            if (o_done) begin
                seen_done = 1'b1;
                got_n = c;
                got_data = o_load_data;
                got_mis = o_misaligned;
            end
        end
        chk("done_seen", {31'd0, seen_done}, 32'd1);
        chk("addr_aligned", {31'd0, addr_bad}, 32'd0);
        @(negedge i_clk);
        chk("ready_after", {31'd0, o_ready}, 32'd1);
    endtask

    typedef struct {
        t_mem_op     op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_data;
        logic        exp_mis;
        int          exp_n;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
    } vec_t;

    vec_t vecs [11];

    // Reference model state: plain byte array mirroring the 32-byte memory.
    logic [7:0] refb [0:31];

    task automatic ref_op(input t_mem_op op, input logic [31:0] addr, input logic [31:0] sd,
                          output logic [31:0] e_data, output logic e_mis, output int e_n,
                          output int e_wr);
        int  sz;
        bit  st, sgn, split, blocked;
        logic [31:0] v;
        case (op)
            LB, LBU, SB: sz = 1;
            LH, LHU, SH: sz = 2;
            default:     sz = 4;
        endcase
        st  = (op == SB) || (op == SH) || (op == SW);
        sgn = (op == LB) || (op == LH);
        split   = (int'(addr[1:0]) + sz) > 4;
        blocked = split && !EN;
        e_mis = blocked;
        e_n   = (split && EN) ? 2 : 1;
        e_wr  = (st && !blocked) ? (split ? 2 : 1) : 0;
        v = 32'h0;
        if (!st && !blocked) begin
            for (int i = 0; i < sz; i++) v = v | (32'(refb[(addr + 32'(i)) & 32'd31]) << (8 * i));
            if (sgn && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        end
        if (st && !blocked)
            for (int i = 0; i < sz; i++) refb[(addr + 32'(i)) & 32'd31] = 8'(sd >> (8 * i));
        e_data = v;
    endtask

    logic [31:0] e_data;
    logic        e_mis;
    int          e_n;
    int          e_wr;

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_op = LB; i_address = 32'h0; i_store_data = 32'h0;
        vecs[0]  = '{LW,  32'h0000_0000, 32'h0, 32'h8033_2211, 1'b0, 1, 32'h8033_2211, 32'h8877_6655};
        vecs[1]  = '{LB,  32'h0000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 32'h8033_2211, 32'h8877_6655};
        vecs[2]  = '{LBU, 32'h0000_0003, 32'h0, 32'h0000_0080, 1'b0, 1, 32'h8033_2211, 32'h8877_6655};
        vecs[3]  = '{LH,  32'h0000_0002, 32'h0, 32'hFFFF_8033, 1'b0, 1, 32'h8033_2211, 32'h8877_6655};
        vecs[4]  = '{LHU, 32'h0000_0002, 32'h0, 32'h0000_8033, 1'b0, 1, 32'h8033_2211, 32'h8877_6655};
        vecs[5]  = '{SH,  32'h0000_0006, 32'h0000_ABCD, 32'h0, 1'b0, 1, 32'h8033_2211, 32'hABCD_6655};
        vecs[6]  = '{LW,  32'h0000_0002, 32'h0, EN ? 32'h6655_8033 : 32'h0, !EN, EN ? 2 : 1,
                     32'h8033_2211, 32'h8877_6655};
        vecs[7]  = '{SW,  32'h0000_0003, 32'hDEAD_BEEF, 32'h0, !EN, EN ? 2 : 1,
                     EN ? 32'hEF33_2211 : 32'h8033_2211, EN ? 32'h88DE_ADBE : 32'h8877_6655};
        vecs[8]  = '{LH,  32'h0000_0003, 32'h0, EN ? 32'h0000_5580 : 32'h0, !EN, EN ? 2 : 1,
                     32'h8033_2211, 32'h8877_6655};
        vecs[9]  = '{SB,  32'h0000_0005, 32'h1234_5678, 32'h0, 1'b0, 1, 32'h8033_2211, 32'h8877_7855};
        vecs[10] = '{LW,  32'hFFFF_FFFE, 32'h0, EN ? 32'h2211_0000 : 32'h0, !EN, EN ? 2 : 1,
                     32'h8033_2211, 32'h8877_6655};

        repeat (2) @(negedge i_clk);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_we", {31'd0, o_mem_write_enable}, 32'd0);
        chk("rst_mask", {28'd0, o_mem_write_mask}, 32'd0);
        chk("rst_addr", o_mem_address, 32'd0);
        chk("rst_data", o_mem_data | o_load_data, 32'd0);
        i_reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            preload(32'h8033_2211, 32'h8877_6655, 1'b0);
            do_op(vecs[v].op, vecs[v].addr, vecs[v].sd);
            chk($sformatf("vec%0d_data", v), got_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_mis", v), {31'd0, got_mis}, {31'd0, vecs[v].exp_mis});
            chk($sformatf("vec%0d_lat", v), 32'(got_n), 32'(vecs[v].exp_n));
            chk($sformatf("vec%0d_mem0", v), mem[0], vecs[v].exp_m0);
            chk($sformatf("vec%0d_mem1", v), mem[1], vecs[v].exp_m1);
        end

        // SH lane placement.
        preload(32'h8033_2211, 32'h8877_6655, 1'b0);
        do_op(SH, 32'h0000_0006, 32'h0000_ABCD);
        chk("sh_nwr", 32'(nwr), 32'd1);
        chk("sh_addr", w_addr[0], 32'h0000_0004);
        chk("sh_mask", {28'd0, w_mask[0]}, 32'h0000_000C);
        chk("sh_data", w_data[0], 32'hABCD_0000);

        // Loads never write.
        preload(32'h8033_2211, 32'h8877_6655, 1'b0);
        do_op(LW, 32'h0000_0002, 32'h0);
        chk("lw_nwr", 32'(nwr), 32'd0);

        // Split SW lane placement.
        preload(32'h8033_2211, 32'h8877_6655, 1'b0);
        do_op(SW, 32'h0000_0003, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGNED_EN
        chk("sw_nwr", 32'(nwr), 32'd2);
        chk("sw_addr0", w_addr[0], 32'h0000_0000);
        chk("sw_mask0", {28'd0, w_mask[0]}, 32'h0000_0008);
        chk("sw_data0", w_data[0], 32'hEF00_0000);
        chk("sw_addr1", w_addr[1], 32'h0000_0004);
        chk("sw_mask1", {28'd0, w_mask[1]}, 32'h0000_0007);
        chk("sw_data1", w_data[1], 32'h00DE_ADBE);
`else
        chk("sw_nwr", 32'(nwr), 32'd0);
`endif

        // Reset one cycle after ACCESS1 of the split store.
        preload(32'h8033_2211, 32'h8877_6655, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b1; i_op = SW; i_address = 32'h0000_0003; i_store_data = 32'hDEAD_BEEF;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("mid_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_done", {31'd0, o_done}, 32'd0);
        chk("mid_we", {31'd0, o_mem_write_enable}, 32'd0);
        chk("mid_mask", {28'd0, o_mem_write_mask}, 32'd0);
        chk("mid_addr", o_mem_address, 32'd0);
        chk("mid_data", o_mem_data, 32'd0);
        chk("mid_load", o_load_data, 32'd0);
        chk("mid_mis", {31'd0, o_misaligned}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("mid_mem0", mem[0], EN ? 32'hEF33_2211 : 32'h8033_2211);
        chk("mid_mem1", mem[1], 32'h8877_6655);

        // Random operations against the byte-array model.
        preload($urandom, $urandom, 1'b1);
        for (int w = 0; w < 8; w++)
            for (int b = 0; b < 4; b++) refb[4*w + b] = preload_val[w][8*b +: 8];
        for (int r = 0; r < 200; r++) begin
            t_mem_op     op;
            logic [31:0] addr;
            logic [31:0] sd;
            op   = t_mem_op'($urandom_range(7, 0));
            addr = $urandom;
            sd   = $urandom;
            ref_op(op, addr, sd, e_data, e_mis, e_n, e_wr);
            do_op(op, addr, sd);
            chk($sformatf("rnd%0d_data", r), got_data, e_data);
            chk($sformatf("rnd%0d_mis", r), {31'd0, got_mis}, {31'd0, e_mis});
            chk($sformatf("rnd%0d_lat", r), 32'(got_n), 32'(e_n));
            chk($sformatf("rnd%0d_nwr", r), 32'(nwr), 32'(e_wr));
            for (int w = 0; w < 8; w++)
                chk($sformatf("rnd%0d_mem%0d", r, w), mem[w],
                    {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
